// File: rtl/cache_mm_arbiter_pkg.sv
// Shared encodings and helpers for the I/D-cache main-memory arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int DEF_LAT   = 4;
    localparam int DEF_WORDS = 4;
    localparam int DEF_CNT_W = 20;

    // Increment a counter of width w (w <= 32), holding at its all-ones maximum.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/cache_mm_arbiter_if.sv
// Bundle of cache request/ack, main-memory and status signals around the arbiter.
// The master side is the caches plus memory; the slave side is the arbiter.
interface cache_mm_arbiter_if #(
    parameter int WORDS = 4,
    parameter int CNT_W = 20
);
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              mm_en;
    logic              mm_we;
    logic [31:0]       mm_addr;
    logic [31:0]       mm_wdata;
    logic [31:0]       mm_rdata;
    logic [31:0]       rdata;
    logic              rvalid_i;
    logic              rvalid_d;
    logic [BW-1:0]     beat;
    logic              stall;
    logic [CNT_W-1:0]  cnt_i;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mm_rdata,
        input  i_ack, d_ack, mm_en, mm_we, mm_addr, mm_wdata, rdata,
               rvalid_i, rvalid_d, beat, stall, cnt_i, cnt_d, cnt_busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mm_rdata,
        output i_ack, d_ack, mm_en, mm_we, mm_addr, mm_wdata, rdata,
               rvalid_i, rvalid_d, beat, stall, cnt_i, cnt_d, cnt_busy
    );

endinterface

// File: rtl/cache_mm_arbiter_rr_pick.sv
// Combinational two-way round-robin pick between I-cache and D-cache requests.
module mm_rr_pick
    import cache_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = REQ_I;
        if (i_req && d_req) begin
            grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/cache_mm_arbiter.sv
// Shares the single main-memory port between I-cache refills and D-cache
// refills/write-throughs, models the fixed access latency, streams refill
// words back and keeps saturating traffic counters.
module cache_mm_arbiter
    import cache_pkg::*;
#(
    parameter int LAT   = DEF_LAT,
    parameter int WORDS = DEF_WORDS,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic rst_n,
    cache_mm_arbiter_if.slave bus
);

    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW = (LAT > 1) ? $clog2(LAT + 1) : 1;
    localparam logic [LW-1:0] LAT_LAST  = LW'(LAT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(WORDS - 1);
    localparam logic [31:0]   BLK_MASK  = ~(32'(WORDS * 4) - 32'd1);
    localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

    state_t           state_q;
    state_t           state_d;
    req_id_t          owner_q;
    req_id_t          last_q;
    logic [31:0]      base_q;
    logic [31:0]      wdata_q;
    logic             is_write_q;
    logic [LW-1:0]    lat_q;
    logic [BW-1:0]    beat_q;
    logic [CNT_W-1:0] cnt_i_q;
    logic [CNT_W-1:0] cnt_d_q;
    logic [CNT_W-1:0] cnt_busy_q;
    logic             grant_valid;
    req_id_t          grant_id;
    logic             lat_done;
    logic             beat_done;
    logic             i_ack_c;
    logic             d_ack_c;

    mm_rr_pick u_pick (
        .i_req       (bus.i_req),
        .d_req       (bus.d_req),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign lat_done  = (lat_q == LAT_LAST);
    assign beat_done = (beat_q == BEAT_LAST);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant, latency wait, burst transfer (reads only), one-cycle ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_valid) state_d = WAIT;
            WAIT: if (lat_done) state_d = is_write_q ? DONE : XFER;
            XFER: if (beat_done) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state so they drop as soon as reset hits.
    always_comb begin
        bus.mm_en    = 1'b0;
        bus.mm_we    = 1'b0;
        bus.mm_addr  = 32'd0;
        bus.mm_wdata = 32'd0;
        bus.rdata    = 32'd0;
        bus.rvalid_i = 1'b0;
        bus.rvalid_d = 1'b0;
        bus.beat     = '0;
        i_ack_c      = 1'b0;
        d_ack_c      = 1'b0;
        case (state_q)
            WAIT: begin
                bus.mm_en   = 1'b1;
                bus.mm_addr = base_q;
                if (is_write_q && lat_done) begin
                    bus.mm_we    = 1'b1;
                    bus.mm_wdata = wdata_q;
                end
            end
            XFER: begin
                bus.mm_en    = 1'b1;
                bus.mm_addr  = base_q + (32'(beat_q) << 2);
                bus.rdata    = bus.mm_rdata;
                bus.rvalid_i = (owner_q == REQ_I);
                bus.rvalid_d = (owner_q == REQ_D);
                bus.beat     = beat_q;
            end
            DONE: begin
                i_ack_c = (owner_q == REQ_I);
                d_ack_c = (owner_q == REQ_D);
            end
            default: ;
        endcase
        bus.i_ack = i_ack_c;
        bus.d_ack = d_ack_c;
        bus.stall = (bus.i_req & ~i_ack_c) | (bus.d_req & ~d_ack_c);
    end

    // Transaction context: owner, base address, write data, latency and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= REQ_I;
            last_q     <= REQ_I;
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            lat_q      <= '0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_id;
                        last_q  <= grant_id;
                        lat_q   <= '0;
                        beat_q  <= '0;
                        if (grant_id == REQ_D && bus.d_we) begin
                            is_write_q <= 1'b1;
                            base_q     <= bus.d_addr & WORD_MASK;
                            wdata_q    <= bus.d_wdata;
                        end else begin
                            is_write_q <= 1'b0;
                            base_q     <= ((grant_id == REQ_D) ? bus.d_addr : bus.i_addr) & BLK_MASK;
                        end
                    end
                end
                WAIT: begin
                    if (lat_done) begin
                        beat_q <= '0;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                XFER: beat_q <= beat_done ? '0 : beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating traffic counters: grants per requester and non-idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_i_q    <= '0;
            cnt_d_q    <= '0;
            cnt_busy_q <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                if (grant_id == REQ_I) begin
                    cnt_i_q <= CNT_W'(sat_inc(32'(cnt_i_q), CNT_W));
                end else begin
                    cnt_d_q <= CNT_W'(sat_inc(32'(cnt_d_q), CNT_W));
                end
            end
            if (state_q != IDLE) begin
                cnt_busy_q <= CNT_W'(sat_inc(32'(cnt_busy_q), CNT_W));
            end
        end
    end

    assign bus.cnt_i    = cnt_i_q;
    assign bus.cnt_d    = cnt_d_q;
    assign bus.cnt_busy = cnt_busy_q;

endmodule

// File: tb/tb_cache_mm_arbiter.sv
// Testbench for cache_mm_arbiter: scoreboard-checked random traffic on a
// default-sized instance, plus directed checks on a LAT=1/WORDS=1/CNT_W=4 instance.
module tb_cache_mm_arbiter;
    import cache_pkg::*;

    localparam int LAT     = 4;
    localparam int WORDS   = 4;
    localparam int CNT_W   = 20;
    localparam int S_LAT   = 1;
    localparam int S_WORDS = 1;
    localparam int S_CNT_W = 4;
    localparam logic [31:0] BLK_MASK = ~(32'(WORDS * 4) - 32'd1);

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] base;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    txn_t exp_q[$];
    txn_t cur;
    bit   mon_en = 1'b0;
    bit   mon_active = 1'b0;
    int   mon_phase = 0;
    int   last_phase = 0;
    int   k = 0;
    int   exp_cnt_i = 0;
    int   exp_cnt_d = 0;
    int   exp_busy = 0;
    logic model_last = 1'b0;
    logic [5:0] ctrl;
    logic [5:0] ctrl_exp;
    logic ack_i_exp;
    logic ack_d_exp;

    cache_mm_arbiter_if #(.WORDS(WORDS), .CNT_W(CNT_W)) bus0 ();
    cache_mm_arbiter_if #(.WORDS(S_WORDS), .CNT_W(S_CNT_W)) bus1 ();

    cache_mm_arbiter #(.LAT(LAT), .WORDS(WORDS), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    cache_mm_arbiter #(.LAT(S_LAT), .WORDS(S_WORDS), .CNT_W(S_CNT_W)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    // Main-memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus0.mm_rdata = mem_word(bus0.mm_addr);
    assign bus1.mm_rdata = mem_word(bus1.mm_addr);

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Issue one round of requests (called at posedge+1 while the arbiter is idle),
    // push the expected service order, then act as the caches until every ACK is seen.
    task automatic apply_stimulus(input bit ri, input bit rd, input logic [31:0] ia,
                                  input bit dwe, input logic [31:0] da, input logic [31:0] dd);
        txn_t ti;
        txn_t td;
        bit   seen_i;
        bit   seen_d;
        int   guard;
        ti.who = 1'b0; ti.we = 1'b0; ti.base = ia & BLK_MASK; ti.wdata = 32'd0;
        td.who = 1'b1; td.we = dwe;
        td.base = dwe ? (da & 32'hFFFF_FFFC) : (da & BLK_MASK);
        td.wdata = dd;
        if (ri && rd) begin
            if (model_last == 1'b0) begin
                exp_q.push_back(td);
                exp_q.push_back(ti);
            end else begin
                exp_q.push_back(ti);
                exp_q.push_back(td);
            end
        end else if (ri) begin
            exp_q.push_back(ti);
            model_last = 1'b0;
        end else if (rd) begin
            exp_q.push_back(td);
            model_last = 1'b1;
        end
        bus0.i_addr  = ia;
        bus0.d_we    = dwe;
        bus0.d_addr  = da;
        bus0.d_wdata = dd;
        bus0.i_req   = ri;
        bus0.d_req   = rd;
        guard = 0;
        while ((bus0.i_req || bus0.d_req) && guard < 100) begin
            @(negedge clk);
            seen_i = bus0.i_ack;
            seen_d = bus0.d_ack;
            @(posedge clk);
            #1;
            if (seen_i) bus0.i_req = 1'b0;
            if (seen_d) bus0.d_req = 1'b0;
            guard++;
        end
        if (guard >= 100) begin
            report_fail("ack_timeout");
            bus0.i_req = 1'b0;
            bus0.d_req = 1'b0;
        end
    endtask

    // Monitor: pops the next expected transaction when the memory port turns on,
    // then checks every cycle of it against the latency/burst rules.
    always @(negedge clk) begin
        if (mon_en) begin
            ctrl = {bus0.mm_en, bus0.mm_we, bus0.rvalid_i, bus0.rvalid_d, bus0.i_ack, bus0.d_ack};
            ack_i_exp = 1'b0;
            ack_d_exp = 1'b0;
            if (!mon_active && bus0.mm_en) begin
                if (exp_q.size() == 0) begin
                    report_fail("unexpected_grant");
                end else begin
                    cur = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_phase = 1;
                    if (cur.who) exp_cnt_d++;
                    else exp_cnt_i++;
                end
            end
            if (!mon_active) begin
                check_output("idle_ctrl", 32'(ctrl), 32'd0);
            end else begin
                last_phase = cur.we ? LAT + 1 : LAT + WORDS + 1;
                if (mon_phase <= LAT) begin
                    ctrl_exp = {1'b1, (cur.we && mon_phase == LAT), 4'b0000};
                    check_output("wait_ctrl", 32'(ctrl), 32'(ctrl_exp));
                    check_output("wait_addr", bus0.mm_addr, cur.base);
                    if (cur.we && mon_phase == LAT) check_output("write_data", bus0.mm_wdata, cur.wdata);
                end else if (mon_phase < last_phase) begin
                    k = mon_phase - LAT - 1;
                    ctrl_exp = {2'b10, ~cur.who, cur.who, 2'b00};
                    check_output("xfer_ctrl", 32'(ctrl), 32'(ctrl_exp));
                    check_output("xfer_addr", bus0.mm_addr, cur.base + 32'(4 * k));
                    check_output("xfer_beat", 32'(bus0.beat), 32'(k));
                    check_output("xfer_rdata", bus0.rdata, mem_word(cur.base + 32'(4 * k)));
                end else begin
                    ack_i_exp = ~cur.who;
                    ack_d_exp = cur.who;
                    ctrl_exp = {4'b0000, ack_i_exp, ack_d_exp};
                    check_output("done_ctrl", 32'(ctrl), 32'(ctrl_exp));
                    check_output("cnt_i", 32'(bus0.cnt_i), 32'(exp_cnt_i));
                    check_output("cnt_d", 32'(bus0.cnt_d), 32'(exp_cnt_d));
                    check_output("cnt_busy", 32'(bus0.cnt_busy), 32'(exp_busy + last_phase - 1));
                    exp_busy += last_phase;
                    mon_active = 1'b0;
                end
                mon_phase++;
            end
            check_output("stall", 32'(bus0.stall),
                         32'((bus0.i_req & ~ack_i_exp) | (bus0.d_req & ~ack_d_exp)));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   guard;
        bit   seen;
        logic acc;
        bus0.i_req = 1'b0; bus0.i_addr = 32'd0; bus0.d_req = 1'b0;
        bus0.d_we = 1'b0; bus0.d_addr = 32'd0; bus0.d_wdata = 32'd0;
        bus1.i_req = 1'b0; bus1.i_addr = 32'd0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = 32'd0; bus1.d_wdata = 32'd0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_ctrl", 32'({bus0.mm_en, bus0.mm_we, bus0.rvalid_i, bus0.rvalid_d,
                                        bus0.i_ack, bus0.d_ack, bus0.stall}), 32'd0);
        check_output("reset_addr", bus0.mm_addr, 32'd0);
        check_output("reset_rdata", bus0.rdata, 32'd0);
        check_output("reset_cnts", 32'(bus0.cnt_i) | 32'(bus0.cnt_d) | 32'(bus0.cnt_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_ctrl", 32'({bus0.mm_en, bus0.rvalid_i, bus0.rvalid_d,
                                             bus0.i_ack, bus0.d_ack}), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Ties right after reset: D first, and again D on the next tie.
        apply_stimulus(1'b1, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_2238, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_4005, 32'h1111_2222);
        apply_stimulus(1'b1, 1'b0, 32'h0000_004C, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF);
        for (int r = 0; r < 40; r++) begin
            logic [1:0] pat;
            bit         dwe;
            pat = 2'($urandom_range(1, 3));
            dwe = 1'($urandom_range(0, 1));
            apply_stimulus(pat[0], pat[1], $urandom, dwe, $urandom, $urandom);
        end
        @(negedge clk);
        @(negedge clk);
        check_output("scoreboard_drain", 32'(exp_q.size()) | 32'(mon_active), 32'd0);
        mon_en = 1'b0;

        // Reset in the middle of an I refill burst.
        @(posedge clk);
        #1;
        bus0.i_addr = 32'h0000_0200;
        bus0.i_req  = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus0.rvalid_i && guard < 50);
        if (!bus0.rvalid_i) report_fail("xfer_timeout");
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_ctrl", 32'({bus0.mm_en, bus0.rvalid_i, bus0.i_ack}), 32'd0);
        bus0.i_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b0;
        repeat (6) begin
            @(negedge clk);
            acc = acc | bus0.i_ack | bus0.mm_en;
        end
        check_output("abort_no_ack", 32'(acc), 32'd0);

        // LAT=1, WORDS=1 refill: one wait cycle, one beat, ack in cycle 3.
        @(posedge clk);
        #1;
        bus1.i_addr = 32'h0000_0077;
        bus1.i_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("s_c1_ctrl", 32'({bus1.mm_en, bus1.mm_we, bus1.rvalid_i, bus1.rvalid_d,
                                       bus1.i_ack, bus1.d_ack}), 32'b100000);
        check_output("s_c1_addr", bus1.mm_addr, 32'h0000_0074);
        @(negedge clk);
        check_output("s_c2_ctrl", 32'({bus1.mm_en, bus1.mm_we, bus1.rvalid_i, bus1.rvalid_d,
                                       bus1.i_ack, bus1.d_ack}), 32'b101000);
        check_output("s_c2_beat", 32'(bus1.beat), 32'd0);
        check_output("s_c2_rdata", bus1.rdata, mem_word(32'h0000_0074));
        @(negedge clk);
        check_output("s_c3_ctrl", 32'({bus1.mm_en, bus1.mm_we, bus1.rvalid_i, bus1.rvalid_d,
                                       bus1.i_ack, bus1.d_ack}), 32'b000010);
        @(posedge clk);
        #1;
        bus1.i_req = 1'b0;

        // 20 back-to-back D writes on the 4-bit counter instance.
        for (int n = 0; n < 20; n++) begin
            bus1.d_we    = 1'b1;
            bus1.d_addr  = $urandom;
            bus1.d_wdata = $urandom;
            bus1.d_req   = 1'b1;
            guard = 0;
            seen  = 1'b0;
            while (!seen && guard < 20) begin
                @(negedge clk);
                seen = bus1.d_ack;
                guard++;
            end
            if (!seen) report_fail("s_write_timeout");
            @(posedge clk);
            #1;
            bus1.d_req = 1'b0;
        end
        @(negedge clk);
        check_output("s_cnt_d_sat", 32'(bus1.cnt_d), 32'd15);
        check_output("s_cnt_i", 32'(bus1.cnt_i), 32'd1);
        check_output("s_cnt_busy_sat", 32'(bus1.cnt_busy), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
